svmcoeff_sched: RTL and testbench
=================================

Name: svmcoeff_sched

Overview:
Coefficient scheduler feeding the signed SVM weight stream into the head of an svmrow chain, in lock-step with the pixel/feature data-valid. Holds two coefficient banks: host writes the shadow bank while the active bank streams. Bank swap happens only at frame start, so a frame never mixes weight sets. Sits between the host config bus and the svcoeff_in of the first svmrow instance.

Parameters:
COEFW, 9, coefficient width (signed)
WINCOLS, 8, window width in cells
BLOCKSIZE, 32, coefficients per cell
NCOEF, WINCOLS*BLOCKSIZE, coefficients per window row (derived, 256)
AW, clog2(NCOEF), config address width (8)

Ports:
clk  in  1  system clock
reset_n  in  1  async active-low reset
fv_in  in  1  frame valid; rising edge = frame start
dvi_in  in  1  data valid of feature stream
cfg_we  in  1  write strobe, shadow bank
cfg_addr  in  AW  write address
cfg_data  in  COEFW  signed coefficient
cfg_commit  in  1  pulse: request swap at next frame start
svcoeff_out  out  COEFW  signed coefficient to svmrow svcoeff_in
dvo_out  out  1  dvi_in delayed, aligned with svcoeff_out
row_done  out  1  pulse: last coefficient of a row issued
swap_pending  out  1  commit latched, swap not yet done
active_bank  out  1  bank currently streaming
coef_valid  out  1  a committed bank exists
cfg_err  out  1  sticky: out-of-range cfg_addr

Behaviour:
- Reset: all outputs 0, idx 0, state IDLE, active_bank 0, pending 0, coef_valid 0. Bank RAM contents not reset.
- Storage: 2 x NCOEF x COEFW. Shadow = ~active_bank, sampled at cycle start.
- Writes: cfg_we && cfg_addr<NCOEF -> shadow[cfg_addr]<=cfg_data. cfg_addr>=NCOEF -> write dropped, cfg_err<=1 (cleared only by reset). Writes accepted in any state and while pending.
- cfg_commit -> pending<=1. Repeated commits while pending: no effect.
- FSM IDLE/RUN. fv_rise = fv_in && !fv_d.
  - IDLE: fv_rise -> RUN. idx<=0. If pending, or cfg_commit same cycle: active_bank toggles, pending<=0, coef_valid<=1.
  - RUN: dvi_in -> idx<=idx+1. idx==NCOEF-1 wraps to 0 and asserts row_done for 1 cycle, aligned with that coefficient's dvo_out. fv_in low -> IDLE, idx<=0.
  - IDLE ignores dvi_in; dvo_out stays 0.
- Read address = fv_rise ? 0 : idx. On fv_rise, the swap applies to that cycle's read. A dvi_in coinciding with fv_rise reads index 0 of the new bank.
- Latency: 1 cycle. svcoeff_out and dvo_out registered. dvo_out = dvi_in && (RUN || fv_rise). svcoeff_out = coef_valid ? bank[active][addr] : 0. svcoeff_out holds its value when dvo_out=0.
- Write+swap same cycle: the write lands in the pre-swap shadow, i.e. the new active bank, and is visible from the next read.
- fv_in drop mid-row: idx discarded, no row_done. A pending swap waits for the next fv_rise.
- reset_n low mid-frame: immediate return to reset state.

Optional Feature:
SVMCOEFF_CHECKSUM_EN: adds output cfg_sum (COEFW+AW+1 bits, signed). It accumulates the sign-extended cfg_data of every accepted write and clears to 0 on swap. The host compares it before commit. Without the macro: no port, no accumulator; all other behaviour identical.

Test Plan:
- Write shadow[i]=i-128 for i=0..255, commit, fv_in rise, dvi_in held 512 cycles -> svcoeff_out = -128..127 twice. dvo_out follows dvi_in by 1 cycle. row_done at outputs 256 and 512. active_bank=1, coef_valid=1.
- No commit before first frame, dvi_in high -> svcoeff_out=0, coef_valid=0, dvo_out follows dvi.
- Mid-frame commit after rewriting shadow to all 5 -> current frame continues old values. swap_pending=1 until next fv_rise, then first output is 5.
- cfg_commit and fv_rise in the same cycle, with dvi_in high -> swap applies, first svcoeff_out is new bank[0].
- cfg_addr=300 write -> cfg_err=1, no bank change. Sticky until reset_n pulse.
- fv_in dropped at idx=100, new frame -> restarts at index 0, no row_done. Async reset mid-frame -> all outputs 0 within same cycle.

Source files
------------

// File: rtl/svmcoeff_sched.sv
// svmcoeff_sched: double-buffered signed SVM coefficient streamer for the head of an svmrow chain.
// Optional macro SVMCOEFF_CHECKSUM_EN adds cfg_sum, a running sum of accepted shadow writes.
module svmcoeff_sched #(
    parameter int COEFW     = 9,
    parameter int WINCOLS   = 8,
    parameter int BLOCKSIZE = 32,
    parameter int AW        = $clog2(WINCOLS * BLOCKSIZE)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    fv_in,
    input  logic                    dvi_in,
    input  logic                    cfg_we,
    input  logic [AW-1:0]           cfg_addr,
    input  logic signed [COEFW-1:0] cfg_data,
    input  logic                    cfg_commit,
    output logic signed [COEFW-1:0] svcoeff_out,
    output logic                    dvo_out,
    output logic                    row_done,
    output logic                    swap_pending,
    output logic                    active_bank,
    output logic                    coef_valid,
    output logic                    cfg_err
`ifdef SVMCOEFF_CHECKSUM_EN
    ,
    output logic signed [COEFW+AW:0] cfg_sum
`endif
);

    localparam int             NCOEF    = WINCOLS * BLOCKSIZE;
    localparam int             IW       = $clog2(NCOEF);
    localparam logic [AW:0]    NCOEF_L  = (AW+1)'(NCOEF);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NCOEF - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    fv_q;
    logic                    active_q, active_d;
    logic                    pend_q, pend_d;
    logic                    cv_q, cv_d;
    logic                    err_q;
    logic                    dvo_q, row_q;
    logic signed [COEFW-1:0] coef_q;

    logic [COEFW-1:0]        bank_mem [2][NCOEF];

    logic                    fv_rise, swap, issue, row_last, wr_ok, wr_bank;
    logic [IW-1:0]           rd_addr, wr_addr;

    assign fv_rise = fv_in && !fv_q;
    assign wr_ok   = cfg_we && ({1'b0, cfg_addr} < NCOEF_L);
    assign wr_addr = cfg_addr[IW-1:0];
    assign wr_bank = ~active_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        swap     = 1'b0;
        issue    = 1'b0;
        row_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (fv_rise) begin
                    state_d = RUN;
                    swap    = pend_q || cfg_commit;
                    issue   = dvi_in;
                    // a beat coinciding with frame start consumes index 0
                    idx_d   = dvi_in ? IW'(1) : '0;
                end
            end
            RUN: begin
                issue = dvi_in;
                if (!fv_in) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (dvi_in) begin
                    row_last = (idx_q == LAST_IDX);
                    idx_d    = row_last ? '0 : idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign active_d = swap ? ~active_q : active_q;
    assign cv_d     = cv_q | swap;
    assign pend_d   = swap ? 1'b0 : (pend_q | cfg_commit);
    assign rd_addr  = fv_rise ? '0 : idx_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            fv_q     <= 1'b0;
            active_q <= 1'b0;
            pend_q   <= 1'b0;
            cv_q     <= 1'b0;
            err_q    <= 1'b0;
            dvo_q    <= 1'b0;
            row_q    <= 1'b0;
            coef_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            fv_q     <= fv_in;
            active_q <= active_d;
            pend_q   <= pend_d;
            cv_q     <= cv_d;
            err_q    <= err_q | (cfg_we && !wr_ok);
            dvo_q    <= issue;
            row_q    <= row_last;
            // read-before-write: a same-cycle shadow write shows up on the following read
            if (issue) begin
                coef_q <= cv_d ? bank_mem[active_d][rd_addr] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            bank_mem[wr_bank][wr_addr] <= cfg_data;
        end
    end

`ifdef SVMCOEFF_CHECKSUM_EN
    logic signed [COEFW+AW:0] sum_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else if (swap) begin
            sum_q <= '0;
        end else if (wr_ok) begin
            sum_q <= sum_q + {{(AW+1){cfg_data[COEFW-1]}}, cfg_data};
        end
    end

    assign cfg_sum = sum_q;
`endif

    assign svcoeff_out  = coef_q;
    assign dvo_out      = dvo_q;
    assign row_done     = row_q;
    assign swap_pending = pend_q;
    assign active_bank  = active_q;
    assign coef_valid   = cv_q;
    assign cfg_err      = err_q;

endmodule

// File: tb/tb_svmcoeff_sched.sv
// Self-checking bench for svmcoeff_sched: constant vector table, directed frame sequences and a random run against a frame-level model.
module tb_svmcoeff_sched;

    localparam int COEFW     = 9;
    localparam int WINCOLS   = 8;
    localparam int BLOCKSIZE = 32;
    localparam int NCOEF     = WINCOLS * BLOCKSIZE;
    localparam int AW        = 9;   // one spare address bit so out-of-range writes are reachable

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    fv_in = 1'b0;
    logic                    dvi_in = 1'b0;
    logic                    cfg_we = 1'b0;
    logic [AW-1:0]           cfg_addr = '0;
    logic signed [COEFW-1:0] cfg_data = '0;
    logic                    cfg_commit = 1'b0;
    logic signed [COEFW-1:0] svcoeff_out;
    logic                    dvo_out, row_done, swap_pending, active_bank, coef_valid, cfg_err;
`ifdef SVMCOEFF_CHECKSUM_EN
    logic signed [COEFW+AW:0] cfg_sum;
`endif

    always #5 clk = ~clk;

    svmcoeff_sched #(
        .COEFW(COEFW), .WINCOLS(WINCOLS), .BLOCKSIZE(BLOCKSIZE), .AW(AW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .fv_in(fv_in), .dvi_in(dvi_in),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .svcoeff_out(svcoeff_out), .dvo_out(dvo_out), .row_done(row_done),
        .swap_pending(swap_pending), .active_bank(active_bank), .coef_valid(coef_valid),
        .cfg_err(cfg_err)
`ifdef SVMCOEFF_CHECKSUM_EN
        , .cfg_sum(cfg_sum)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Frame-level reference: two banks, a per-frame issued-beat count, swap flags.
    int m_bank [2][NCOEF];
    bit m_prev_fv, m_active, m_pend, m_cv, m_err, m_dvo, m_row;
    int m_n, m_sv;

    typedef struct {
        bit fv; bit dvi; bit we; int addr; int data; bit commit;
        int sv; bit dvo; bit row; bit pend; bit act; bit cv; bit err;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_fv = 0; m_active = 0; m_pend = 0; m_cv = 0; m_err = 0;
        m_dvo = 0; m_row = 0; m_n = 0; m_sv = 0;
    endtask

    task automatic do_reset();
        fv_in = 0; dvi_in = 0; cfg_we = 0; cfg_commit = 0;
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        model_reset();
    endtask

    // Applies one cycle of inputs, advances the model, and compares every output after the edge.
    task automatic cycle(input bit fv, input bit dvi, input bit we, input int addr,
                         input int data, input bit commit);
        bit rise, issue, wb;
        logic signed [COEFW-1:0] d9;
        fv_in = fv; dvi_in = dvi; cfg_we = we; cfg_commit = commit;
        cfg_addr = AW'(addr);
        d9 = COEFW'(data);
        cfg_data = d9;

        rise = fv && !m_prev_fv;
        wb = !m_active;
        if (rise && (m_pend || commit)) begin
            m_active = !m_active; m_cv = 1; m_pend = 0;
        end else if (commit) begin
            m_pend = 1;
        end
        if (rise) m_n = 0;
        issue = dvi && (m_prev_fv || fv);
        m_dvo = issue;
        m_row = 0;
        if (issue) begin
            m_sv  = m_cv ? m_bank[m_active][m_n % NCOEF] : 0;
            m_row = fv && ((m_n % NCOEF) == NCOEF - 1);
            m_n++;
        end
        if (!fv) m_n = 0;
        if (we) begin
            if (addr < NCOEF) m_bank[wb][addr] = int'(d9);
            else m_err = 1;
        end
        m_prev_fv = fv;

        @(posedge clk);
        #1;
        checks++;
        if (int'(svcoeff_out) !== m_sv || dvo_out !== m_dvo || row_done !== m_row ||
            swap_pending !== m_pend || active_bank !== m_active || coef_valid !== m_cv ||
            cfg_err !== m_err) begin
            errors++;
            $display("FAIL model t=%0t: got sv=%0d dvo=%b row=%b pend=%b act=%b cv=%b err=%b expected sv=%0d dvo=%b row=%b pend=%b act=%b cv=%b err=%b",
                     $time, svcoeff_out, dvo_out, row_done, swap_pending, active_bank, coef_valid, cfg_err,
                     m_sv, m_dvo, m_row, m_pend, m_active, m_cv, m_err);
        end
    endtask

    initial begin
        int rowcnt;
        bit rfv, rdvi;

        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NCOEF; i++) m_bank[b][i] = 0;

        //          fv dvi we addr data cm |  sv dvo row pend act cv err
        tbl[0]  = '{0, 0, 0, 0,   0,   0,    0,  0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0,   0,   0,    0,  1, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 0,   0,   0,    0,  1, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0,   0,   0,    0,  0, 0, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 1, 0,   7,   0,    0,  0, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 1, 1,   -3,  0,    0,  0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0,   0,   1,    0,  0, 0, 1, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0,   0,   1,    0,  0, 0, 1, 0, 0, 0};
        tbl[8]  = '{1, 1, 0, 0,   0,   0,    7,  1, 0, 0, 1, 1, 0};
        tbl[9]  = '{1, 0, 0, 0,   0,   0,    7,  0, 0, 0, 1, 1, 0};
        tbl[10] = '{1, 1, 0, 0,   0,   0,    -3, 1, 0, 0, 1, 1, 0};
        tbl[11] = '{0, 0, 1, 300, 1,   0,    -3, 0, 0, 0, 1, 1, 1};
        tbl[12] = '{0, 0, 0, 0,   0,   0,    -3, 0, 0, 0, 1, 1, 1};

        do_reset();
        chk("reset_state", int'({svcoeff_out, dvo_out, row_done, swap_pending, active_bank, coef_valid, cfg_err}), 0);

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].fv, tbl[i].dvi, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].commit);
            checks++;
            if (int'(svcoeff_out) !== tbl[i].sv || dvo_out !== tbl[i].dvo || row_done !== tbl[i].row ||
                swap_pending !== tbl[i].pend || active_bank !== tbl[i].act ||
                coef_valid !== tbl[i].cv || cfg_err !== tbl[i].err) begin
                errors++;
                $display("FAIL table[%0d]: got sv=%0d dvo=%b row=%b pend=%b act=%b cv=%b err=%b expected sv=%0d dvo=%b row=%b pend=%b act=%b cv=%b err=%b",
                         i, svcoeff_out, dvo_out, row_done, swap_pending, active_bank, coef_valid, cfg_err,
                         tbl[i].sv, tbl[i].dvo, tbl[i].row, tbl[i].pend, tbl[i].act, tbl[i].cv, tbl[i].err);
            end
            $display("table[%0d] fv=%b dvi=%b we=%b addr=%0d commit=%b -> sv=%0d dvo=%b act=%b err=%b",
                     i, tbl[i].fv, tbl[i].dvi, tbl[i].we, tbl[i].addr, tbl[i].commit,
                     svcoeff_out, dvo_out, active_bank, cfg_err);
        end

        // Full ramp bank, commit, two rows streamed back to back.
        do_reset();
        chk("A_reset_err", cfg_err, 0);
        for (int i = 0; i < NCOEF; i++) cycle(0, 0, 1, i, i - 128, 0);
        cycle(0, 0, 0, 0, 0, 1);
        chk("A_pending", swap_pending, 1);
        cycle(1, 0, 0, 0, 0, 0);
        chk("A_rise_dvo", dvo_out, 0);
        chk("A_swap_bank", active_bank, 1);
        rowcnt = 0;
        for (int k = 0; k < 2 * NCOEF; k++) begin
            cycle(1, 1, 0, 0, 0, 0);
            chk("A_sv", int'(svcoeff_out), (k % NCOEF) - 128);
            chk("A_row", row_done, ((k % NCOEF) == NCOEF - 1) ? 1 : 0);
            rowcnt += int'(row_done);
        end
        chk("A_rowcount", rowcnt, 2);
        chk("A_coef_valid", coef_valid, 1);
        $display("seqA ramp stream 512 beats rows=%0d act=%b", rowcnt, active_bank);

        // Shadow rewritten to 5 mid-frame with a commit: current frame keeps old weights.
        for (int j = 0; j < NCOEF; j++) begin
            cycle(1, 1, 1, j, 5, j == 128);
            chk("C_old_sv", int'(svcoeff_out), j - 128);
        end
        chk("C_pending", swap_pending, 1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("C_pending_idle", swap_pending, 1);
        cycle(1, 1, 0, 0, 0, 0);
        chk("C_new_first", int'(svcoeff_out), 5);
        chk("C_active", active_bank, 0);
        chk("C_pending_clr", swap_pending, 0);
        cycle(1, 1, 0, 0, 0, 0);
        chk("C_new_second", int'(svcoeff_out), 5);
        cycle(0, 0, 0, 0, 0, 0);
        $display("seqC mid-frame commit swapped at next frame sv=%0d", svcoeff_out);

        // Out-of-range write must not alias into the shadow, then commit coinciding with frame start.
        cycle(0, 0, 1, 300, 0, 0);
        chk("E_err", cfg_err, 1);
        cycle(1, 1, 0, 0, 0, 1);
        chk("D_active", active_bank, 1);
        chk("D_first", int'(svcoeff_out), -128);
        for (int k = 1; k < 64; k++) begin
            cycle(1, 1, 0, 0, 0, 0);
            chk("D_sv", int'(svcoeff_out), k - 128);
        end
        cycle(0, 0, 0, 0, 0, 0);
        chk("E_err_sticky", cfg_err, 1);
        do_reset();
        chk("E_err_clr", cfg_err, 0);
        chk("E_reset_sv", int'(svcoeff_out), 0);
        $display("seqDE commit at frame start, bad address dropped, err cleared by reset");

        // Frame dropped at index 100: no row_done, next frame restarts at index 0.
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0);
        rowcnt = 0;
        for (int k = 0; k < 100; k++) begin
            cycle(1, 1, 0, 0, 0, 0);
            chk("F_sv", int'(svcoeff_out), k - 128);
            rowcnt += int'(row_done);
        end
        cycle(0, 0, 0, 0, 0, 0);
        rowcnt += int'(row_done);
        cycle(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cycle(1, 1, 0, 0, 0, 0);
            chk("F_restart_sv", int'(svcoeff_out), k - 128);
            rowcnt += int'(row_done);
        end
        chk("F_no_row", rowcnt, 0);
        $display("seqF frame drop at idx 100 restart ok rows=%0d", rowcnt);

        // Asynchronous reset mid-frame clears outputs without a clock edge.
        cycle(1, 1, 0, 0, 0, 0);
        #2;
        reset_n = 0;
        #1;
        chk("G_async_reset", int'({svcoeff_out, dvo_out, row_done, swap_pending, active_bank, coef_valid, cfg_err}), 0);
        fv_in = 0; dvi_in = 0;
        @(posedge clk);
        #1;
        reset_n = 1;
        model_reset();
        $display("seqG async reset mid-frame");

        // Random traffic against the model.
        rfv = 0;
        for (int r = 0; r < 4000; r++) begin
            bit prev;
            prev = rfv;
            if ($urandom_range(0, 149) == 0) rfv = !rfv;
            rdvi = rfv && ($urandom_range(0, 3) != 0);
            cycle(rfv, rdvi, $urandom_range(0, 2) == 0, int'($urandom_range(0, 299)),
                  int'($urandom_range(0, 511)) - 256, $urandom_range(0, 79) == 0);
            if (rfv && !prev)
                $display("rand frame start cycle=%0d act=%b cv=%b err=%b", r, active_bank, coef_valid, cfg_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
